// File: rtl/rs_dec_pkg.sv
// Shared defaults and address-decode helpers for the pipelined RS write decoder.
package rs_dec_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NCH      = 12;
  localparam int DEF_BCAST    = 1;
  localparam int DEF_ERRCNT_W = 8;

  localparam logic [DEF_ADDR_W-1:0] BCAST_ADDR = {DEF_ADDR_W{1'b1}};

  // An address is usable if it names a real channel, or is the broadcast code when enabled.
  function automatic logic addr_ok(input logic [31:0] addr, input int nch,
                                   input int addr_w, input bit bcast);
    logic [31:0] all_ones;
    all_ones = (32'd1 << addr_w) - 32'd1;
    return (addr < 32'(nch)) || (bcast && (addr == all_ones));
  endfunction

  // One bit of the channel select: a single match inside range, every bit on broadcast.
  function automatic logic sel_hit(input logic [31:0] addr, input int ch, input int nch,
                                   input int addr_w, input bit bcast);
    if (addr < 32'(nch)) begin
      return addr == 32'(ch);
    end else begin
      return addr_ok(addr, nch, addr_w, bcast);
    end
  endfunction

endpackage

// File: rtl/rs_write_decoder_pipe_stage.sv
// Generic valid/ready register slice; full bit plus payload register.
module rs_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic full;
  logic load;

  assign in_ready  = !full || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = full;

  // Occupancy and payload; a simultaneous drain and refill keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      out_data <= '0;
    end else if (load) begin
      full     <= 1'b1;
      out_data <= in_data;
    end else if (out_ready) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/rs_write_decoder_pipe.sv
// Two-stage RS write decoder: S1 captures/decodes, S2 drives the outputs.
// Optional RS_PARITY_CHECK_EN adds an even-parity MSB on in_word and par_err_flag.
module rs_write_decoder_pipe
  import rs_dec_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NCH      = DEF_NCH,
  parameter int BCAST    = DEF_BCAST,
  parameter int ERRCNT_W = DEF_ERRCNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef RS_PARITY_CHECK_EN
  input  logic [ADDR_W+DATA_W:0]   in_word,
`else
  input  logic [ADDR_W+DATA_W-1:0] in_word,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH-1:0]           out_sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [ERRCNT_W-1:0]      err_cnt,
  output logic                     err_flag,
`ifdef RS_PARITY_CHECK_EN
  output logic                     par_err_flag,
`endif
  input  logic                     clr_err,
  output logic [15:0]              wr_cnt
);

  localparam int CW = ADDR_W + DATA_W;
  localparam int PW = NCH + DATA_W;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [NCH-1:0]    sel;
  logic              ok;
  logic              par_bad;
  logic              accept;
  logic              invalid;
  logic              s1_in_valid;
  logic              s1_full;
  logic              s2_ready;
  logic [PW-1:0]     s1_payload;
  logic [PW-1:0]     s2_payload;

  assign addr = in_word[CW-1:DATA_W];
  assign data = in_word[DATA_W-1:0];

`ifdef RS_PARITY_CHECK_EN
  assign par_bad = ^in_word;
`else
  assign par_bad = 1'b0;
`endif

  // Address decode into the channel select vector.
  always_comb begin
    sel = '0;
    ok  = addr_ok(32'(addr), NCH, ADDR_W, BCAST != 0);
    for (int i = 0; i < NCH; i++) begin
      sel[i] = sel_hit(32'(addr), i, NCH, ADDR_W, BCAST != 0);
    end
  end

  // Bad words are still consumed so upstream never stalls on them.
  assign accept      = in_valid && in_ready;
  assign invalid     = accept && (!ok || par_bad);
  assign s1_in_valid = in_valid && ok && !par_bad;

  rs_pipe_stage #(.W(PW)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel, data}),
    .out_valid (s1_full),
    .out_ready (s2_ready),
    .out_data  (s1_payload)
  );

  rs_pipe_stage #(.W(PW)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_full),
    .in_ready  (s2_ready),
    .in_data   (s1_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_payload)
  );

  assign out_sel  = s2_payload[PW-1:DATA_W];
  assign out_data = s2_payload[DATA_W-1:0];

  // Invalid-address bookkeeping; clear takes priority but a same-cycle error still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (clr_err) begin
      err_cnt  <= invalid ? ERRCNT_W'(1) : ERRCNT_W'(0);
      err_flag <= invalid;
    end else if (invalid) begin
      if (err_cnt != {ERRCNT_W{1'b1}}) begin
        err_cnt <= err_cnt + ERRCNT_W'(1);
      end
      err_flag <= 1'b1;
    end
  end

`ifdef RS_PARITY_CHECK_EN
  // Sticky parity error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_flag <= 1'b0;
    end else if (clr_err) begin
      par_err_flag <= accept && par_bad;
    end else if (accept && par_bad) begin
      par_err_flag <= 1'b1;
    end
  end
`endif

  // Forwarded-write counter, free running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= 16'd0;
    end else if (out_valid && out_ready) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rs_write_decoder_pipe.sv
// Drives a broadcast and a non-broadcast decoder with shared stimulus and checks both
// against a transaction-level model (FIFO of depth 2 with acceptance timestamps).
module tb_rs_write_decoder_pipe;
  import rs_dec_pkg::*;

  localparam int AW  = DEF_ADDR_W;
  localparam int DW  = DEF_DATA_W;
  localparam int NCH = DEF_NCH;
  localparam int EW  = DEF_ERRCNT_W;
`ifdef RS_PARITY_CHECK_EN
  localparam int IW  = AW + DW + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int IW  = AW + DW;
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] in_word = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_err = 1'b0;

  logic [1:0]     in_rdy, o_vld, e_flag, p_flag;
  logic [NCH-1:0] o_sel [2];
  logic [DW-1:0]  o_data [2];
  logic [EW-1:0]  e_cnt [2];
  logic [15:0]    w_cnt [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index 0 is the broadcast build, index 1 the non-broadcast build.
  int             m_cnt [2];
  logic [NCH-1:0] m_sel [2][2];
  logic [DW-1:0]  m_data [2][2];
  int             m_stamp [2][2];
  int             m_err [2];
  bit             m_flag [2];
  bit             m_pflag [2];
  int             m_wr [2];
  int             now = 0;

  always #5 clk = ~clk;

  rs_write_decoder_pipe #(.ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .BCAST(1), .ERRCNT_W(EW)) dut_bc (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_sel(o_sel[0]), .out_data(o_data[0]),
    .err_cnt(e_cnt[0]), .err_flag(e_flag[0]),
`ifdef RS_PARITY_CHECK_EN
    .par_err_flag(p_flag[0]),
`endif
    .clr_err(clr_err), .wr_cnt(w_cnt[0]));

  rs_write_decoder_pipe #(.ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .BCAST(0), .ERRCNT_W(EW)) dut_nb (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_sel(o_sel[1]), .out_data(o_data[1]),
    .err_cnt(e_cnt[1]), .err_flag(e_flag[1]),
`ifdef RS_PARITY_CHECK_EN
    .par_err_flag(p_flag[1]),
`endif
    .clr_err(clr_err), .wr_cnt(w_cnt[1]));

`ifndef RS_PARITY_CHECK_EN
  assign p_flag = 2'b00;
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_err[d] = 0; m_flag[d] = 1'b0; m_pflag[d] = 1'b0; m_wr[d] = 0;
    end
  endtask

  // Async reset asserted mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    clr_err  = 1'b0;
    rst      = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("rst%0d_out_valid", d), 64'(o_vld[d]), 64'd0);
      check_val($sformatf("rst%0d_in_ready", d), 64'(in_rdy[d]), 64'd1);
      check_val($sformatf("rst%0d_err_cnt", d), 64'(e_cnt[d]), 64'd0);
      check_val($sformatf("rst%0d_err_flag", d), 64'(e_flag[d]), 64'd0);
      check_val($sformatf("rst%0d_wr_cnt", d), 64'(w_cnt[d]), 64'd0);
      if (PAR) check_val($sformatf("rst%0d_par_flag", d), 64'(p_flag[d]), 64'd0);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive, check both DUTs against the model, predict the edge, advance.
  task automatic step(input logic iv, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                      input bit bad_in, input logic ordy, input logic clr, output bit acc0);
    logic [AW+DW-1:0] w;
    bit bad;
    bad = PAR && bad_in;
    w   = {a, dt};
    in_valid  = iv;
    out_ready = ordy;
    clr_err   = clr;
`ifdef RS_PARITY_CHECK_EN
    in_word = {(^w) ^ bad, w};
`else
    in_word = w;
`endif
    #1;
    acc0 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      bit ev, er, ok, inv;
      logic [NCH-1:0] es;
      int ai;
      ev = (m_cnt[d] > 0) && (m_stamp[d][0] < now);
      er = (m_cnt[d] < 2) || ordy;
      check_val($sformatf("d%0d_in_ready", d), 64'(in_rdy[d]), 64'(er));
      check_val($sformatf("d%0d_out_valid", d), 64'(o_vld[d]), 64'(ev));
      if (ev) begin
        check_val($sformatf("d%0d_out_sel", d), 64'(o_sel[d]), 64'(m_sel[d][0]));
        check_val($sformatf("d%0d_out_data", d), 64'(o_data[d]), 64'(m_data[d][0]));
      end
      check_val($sformatf("d%0d_err_cnt", d), 64'(e_cnt[d]), 64'(m_err[d]));
      check_val($sformatf("d%0d_err_flag", d), 64'(e_flag[d]), 64'(m_flag[d]));
      check_val($sformatf("d%0d_wr_cnt", d), 64'(w_cnt[d]), 64'(m_wr[d]));
      if (PAR) check_val($sformatf("d%0d_par_flag", d), 64'(p_flag[d]), 64'(m_pflag[d]));
      if (ev && ordy) begin
        m_sel[d][0] = m_sel[d][1]; m_data[d][0] = m_data[d][1]; m_stamp[d][0] = m_stamp[d][1];
        m_cnt[d]--;
        m_wr[d] = (m_wr[d] + 1) % 65536;
      end
      ai = int'(a);
      ok = 1'b0;
      es = '0;
      if (ai < NCH) begin
        ok = 1'b1;
        es = NCH'(1) << ai;
      end else if (d == 0 && a == BCAST_ADDR) begin
        ok = 1'b1;
        es = '1;
      end
      inv = iv && er && (bad || !ok);
      if (iv && er && !bad && ok) begin
        m_sel[d][m_cnt[d]]   = es;
        m_data[d][m_cnt[d]]  = dt;
        m_stamp[d][m_cnt[d]] = now + 1;
        m_cnt[d]++;
        if (d == 0) acc0 = 1'b1;
      end
      if (clr) begin
        m_err[d]   = inv ? 1 : 0;
        m_flag[d]  = inv;
        m_pflag[d] = iv && er && bad;
      end else if (inv) begin
        m_err[d]  = (m_err[d] >= (1 << EW) - 1) ? (1 << EW) - 1 : m_err[d] + 1;
        m_flag[d] = 1'b1;
        if (bad) m_pflag[d] = 1'b1;
      end
    end
    now++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int k;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single word, then broadcast / invalid-broadcast address.
    step(1'b1, 4'h3, 8'hA5, 1'b0, 1'b1, 1'b0, acc);
    idle(3);
    check_val("wr_cnt_first", 64'(w_cnt[0]), 64'd1);
    step(1'b1, 4'hF, 8'h55, 1'b0, 1'b1, 1'b0, acc);
    idle(3);
    check_val("nb_bcast_err", 64'(e_cnt[1]), 64'd1);

    // Out-of-range addresses back to back, then saturate the counter and clear it.
    for (int i = 12; i < 15; i++) step(1'b1, AW'(i), 8'h00, 1'b0, 1'b1, 1'b0, acc);
    idle(2);
    for (int i = 0; i < 300; i++) step(1'b1, 4'hD, 8'($urandom), 1'b0, 1'b1, 1'b0, acc);
    idle(1);
    check_val("err_sat_bc", 64'(e_cnt[0]), 64'hFF);
    check_val("err_sat_nb", 64'(e_cnt[1]), 64'hFF);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    check_val("err_clr", 64'(e_cnt[0]), 64'd0);

    // Six words with a downstream stall on cycles 3-8.
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      step(k < 6, AW'(k % NCH), 8'h10 + 8'(k), 1'b0, !(c >= 3 && c <= 8), 1'b0, acc);
      if (acc) k++;
    end
    check_val("stall_words_taken", 64'(k), 64'd6);

    // Reset with two words in flight.
    step(1'b1, 4'h1, 8'h11, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 4'h2, 8'h22, 1'b0, 1'b0, 1'b0, acc);
    do_reset();
    idle(4);

`ifdef RS_PARITY_CHECK_EN
    step(1'b1, 4'h3, 8'hA5, 1'b1, 1'b1, 1'b0, acc);
    idle(2);
    check_val("par_flag_set", 64'(p_flag[0]), 64'd1);
    step(1'b1, 4'h3, 8'hA5, 1'b0, 1'b1, 1'b0, acc);
    idle(3);
`endif

    // Randomized traffic with backpressure, occasional clears and parity faults.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, AW'($urandom), 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_write_decoder_pipe.md
Name: rs_write_decoder_pipe

Overview:
Parametrised, pipelined successor to the 12-bit combinational RS write decoder.
- Accepts one command word per handshake: address field in the upper bits, data in the lower bits.
- Decodes the address into one-hot write selects across NCH channels and forwards data with valid/ready backpressure.
- Counts invalid addresses; supports a broadcast address.
- Sits between the pad-level input assembly and the per-channel write targets.

Parameters:
ADDR_W, 4, address field width; bits [ADDR_W+DATA_W-1:DATA_W] of in_word
DATA_W, 8, data field width; bits [DATA_W-1:0] of in_word
NCH, 12, number of write channels; must satisfy NCH < 2**ADDR_W
BCAST, 1, 1 = all-ones address selects every channel; 0 = all-ones address is invalid
ERRCNT_W, 8, width of the saturating invalid-address counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_word  input  ADDR_W+DATA_W  command word {addr, data}
in_valid  input  1  command present
in_ready  output  1  block accepts in_word this cycle
out_valid  output  1  decoded write present
out_ready  input  1  downstream accepts the write
out_sel  output  NCH  one-hot or broadcast channel select
out_data  output  DATA_W  write data
err_cnt  output  ERRCNT_W  count of invalid addresses, saturating
err_flag  output  1  sticky invalid-address flag
clr_err  input  1  synchronous clear of err_cnt and err_flag
wr_cnt  output  16  count of forwarded writes, wrapping

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: every output register is 0, both pipeline stages are empty, in_ready=1.
- Pipeline stages: S1 captures and decodes; S2 is the output register. Each stage has its own full bit.
- Latency: 2 cycles. A word accepted at edge N is presented at out_valid after edge N+1. Sustained throughput is 1 word/cycle while out_ready=1.
- S2 advance: S2 loads when S2 is empty or (out_valid && out_ready).
- S1 advance: S1 loads when S1 is empty or S1 moves to S2 in the same cycle.
- in_ready: in_ready = !s1_full || s1_moving. It is combinational from out_ready, with no path from in_valid.
- Handshake: a transfer happens only when valid && ready on the same edge. While out_valid=1 and out_ready=0, out_sel and out_data hold stable.
- Decode:
  - addr < NCH → out_sel has only bit addr set.
  - addr == all-ones and BCAST=1 → out_sel is all ones.
  - Any other address is invalid: the word is consumed, S1 stays empty, and no output is produced.
- Invalid address: sets err_flag; err_cnt increments and saturates at all-ones.
- clr_err clears err_cnt and err_flag. If clr_err and an invalid word occur in the same cycle, clear wins, then the count is 1 and err_flag=1.
- wr_cnt increments on each out_valid && out_ready and wraps 0xFFFF→0.
- Reset mid-operation: both stages are flushed and in-flight words are lost. No out_valid in the cycle after rst deasserts.

Optional Feature:
RS_PARITY_CHECK_EN
- Defined:
  - in_word gains one extra MSB: even parity over {addr, data}.
  - A word with a parity mismatch is treated as invalid: dropped, counted in err_cnt, and sets err_flag.
  - Adds output par_err_flag, sticky and cleared by clr_err.
- Undefined: in_word is exactly ADDR_W+DATA_W wide, there is no parity logic, and par_err_flag is absent.

Decomposition:
- Package rs_dec_pkg holds:
  - constant BCAST_ADDR (all-ones of ADDR_W)
  - a function for one-hot decode with a range check
  - default parameter values
- Sub-module rs_pipe_stage: a generic valid/ready register slice with a payload-width parameter. It is instantiated twice, for S1 and S2.

Test Plan:
- Defaults, out_ready=1, in_word=12'h3A5 valid 1 cycle → 2 cycles later out_valid=1, out_sel=12'h008, out_data=8'hA5; wr_cnt=1.
- in_word=12'hF55, BCAST=1 → out_sel=12'hFFF, out_data=8'h55. Same stimulus with BCAST=0 → no out_valid, err_cnt=1, err_flag=1.
- addr 12,13,14 back-to-back → 0 writes out, err_cnt=3. Then 300 invalid words → err_cnt=8'hFF. Then clr_err → err_cnt=0, err_flag=0.
- Stream 6 valid words with out_ready=0 for cycles 3-8:
  - in_ready drops after 2 words are held.
  - out_sel/out_data stay stable while stalled.
  - After release, all 6 words arrive in order with none lost or duplicated.
- Assert rst while 2 words are in flight → out_valid=0 immediately, in_ready=1, counters=0, and nothing appears after release.
- RS_PARITY_CHECK_EN defined: word with a bad parity bit → dropped, par_err_flag=1, err_cnt+1. Correct parity → normal decode.
